// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: scheduler state encoding,
// frame length helper and default frame format.
`default_nettype none

package uart_pkg;

  localparam int DBITS_DEF   = 8;
  localparam int SB_TICK_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } sched_state_e;

  // 16 oversampling ticks each for the start bit and every data bit, plus the stop bit.
  function automatic int frame_ticks(input int dbits, input int sb_tick);
    return 16 * (dbits + 1) + sb_tick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i,
// searching upward with wrap-around.
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDXW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDXW-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDXW-1:0]  idx_o,
  output logic             any_o
);

  logic [IDXW-1:0] pos;
  logic            found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    pos   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = IDXW'((int'(ptr_i) + k) % N_REQ);
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

  assign any_o = |req_i;

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ producers;
// frame completion is inferred by counting oversampling ticks.
`default_nettype none

module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DBITS   = DBITS_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic                       clk_100MHz,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       sample_tick,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DBITS-1:0]     req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       tx_start,
  output logic [DBITS-1:0]           data_out,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       frame_done
);

  localparam int FRAME_TICKS = frame_ticks(DBITS, SB_TICK);
  localparam int CW          = $clog2(FRAME_TICKS);
  localparam int IDXW        = $clog2(N_REQ);

  sched_state_e    state_q;
  logic [IDXW-1:0] rr_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [DBITS-1:0] data_q;
  logic [IDXW-1:0] grant_q;
  logic            busy_q;
  logic            tx_start_q;
  logic            frame_done_q;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDXW-1:0]  arb_idx;
  logic             arb_any;
  logic             grant_now;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDXW  (IDXW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign grant_now = (state_q == ST_IDLE) && enable && arb_any;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_now) begin
            data_q     <= req_data[arb_idx*DBITS +: DBITS];
            grant_q    <= arb_idx;
            rr_ptr_q   <= (arb_idx == IDXW'(N_REQ-1)) ? '0 : arb_idx + 1'b1;
            busy_q     <= 1'b1;
            tx_start_q <= 1'b1;
            state_q    <= ST_LOAD;
          end
        end
        // The transmitter is still idle here, so a tick in this cycle is not counted.
        ST_LOAD: begin
          cnt_q   <= '0;
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          if (sample_tick) begin
            if (cnt_q == CW'(FRAME_TICKS-1)) begin
              frame_done_q <= 1'b1;
              state_q      <= ST_GAP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_GAP: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = grant_now ? arb_gnt : '0;
  assign tx_start   = tx_start_q;
  assign data_out   = data_q;
  assign busy       = busy_q;
  assign grant_id   = grant_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one `uart_transmitter` among `N_REQ` byte producers. It accepts a word from one requester at a time and issues a single-cycle `tx_start` with the word on `data_out`. It then tracks frame progress by counting `sample_tick`, because the transmitter exposes no busy/done signal. It sits between the system's message sources and the transmitter, and shares the transmitter's clock, reset and baud tick.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `DBITS`, 8: data bits per frame; must match the transmitter.
- `SB_TICK`, 16: stop-bit ticks; must match the transmitter.
- `clk_100MHz` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: when low, no new grants are made; an in-flight frame completes.
- `sample_tick` in 1: 16x oversampling tick from the baud generator.
- `req_valid` in `N_REQ`: requester i has a word pending.
- `req_data` in `N_REQ*DBITS`: word of requester i in bits `[i*DBITS +: DBITS]`.
- `req_ready` out `N_REQ`: one-hot, one-cycle acceptance pulse.
- `tx_start` out 1: one-cycle start pulse to the transmitter.
- `data_out` out `DBITS`: word to the transmitter's `data_in`; held stable from `tx_start` until the next grant.
- `busy` out 1: high from grant until the frame completes.
- `grant_id` out `$clog2(N_REQ)`: index of the last granted requester.
- `frame_done` out 1: one-cycle pulse when a frame's stop bit ends.

## Operation
- Frame length in ticks: `FRAME_TICKS = 16*(DBITS+1) + SB_TICK`, which is 160 for the defaults.
- Tick counter width: `$clog2(FRAME_TICKS)`.
- **IDLE**
  - If `enable` and any `req_valid`, pick the first valid index at or after `rr_ptr`, searching upward with wrap.
  - Same cycle: pulse `req_ready[i]`.
  - Next edge: `data_out <= req_data[i]`, `grant_id <= i`, `rr_ptr <= (i+1) mod N_REQ`, `busy <= 1`; go to LOAD.
- **LOAD**
  - `tx_start` = 1 for this cycle only; tick counter cleared.
  - A `sample_tick` in this cycle is not counted, because the transmitter ignores ticks while idle.
  - Go to SEND.
- **SEND**
  - Increment the counter on each `sample_tick`.
  - On a tick with `count == FRAME_TICKS-1`, go to GAP. The transmitter reaches idle on the same edge.
- **GAP**
  - Single cycle: `frame_done` = 1 and `busy` drops at its end; go to IDLE.
- `req_valid` dropping after acceptance has no effect.
- A requester whose `req_valid` is high while another is being served waits; no words are lost.
- `enable` is checked only in IDLE.
- `data_out` is registered and never changes during LOAD, SEND or GAP.
- `req_ready`, `tx_start` and `frame_done` are mutually exclusive in time.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` 0.
  - Counter, `tx_start`, `data_out`, `busy`, `grant_id`, `frame_done`, `req_ready`: all 0.
- `reset` asserted mid-frame aborts immediately. The transmitter resets on the same signal, so no partial resume is expected.
- Latency, with `req_valid` high in IDLE at cycle t:
  - `req_ready` at t.
  - `tx_start` at t+1.
  - First tick counted at t+2 or later.
- Back-to-back frames: after the final tick edge, GAP is one cycle, then IDLE grants. The next `tx_start` comes 2 cycles after GAP, and the transmitter is already idle.
- Counter wrap: the counter is cleared in LOAD only; the FSM leaves SEND before any overflow.
- Simultaneous requests: round-robin from `rr_ptr`.
  - All four valid with `rr_ptr = 0` grants 0, 1, 2, 3, 0, …
- `sample_tick` and a state transition in the same cycle: the tick counts only if the FSM is in SEND during that cycle.

## Structure
- Shared package `uart_pkg` holds:
  - the scheduler state encoding (IDLE, LOAD, SEND, GAP; 2 bits);
  - the `FRAME_TICKS` function of `DBITS` and `SB_TICK`;
  - default `DBITS` and `SB_TICK`, so the scheduler and transmitter cannot drift.
- Sub-module `rr_arbiter`: combinational. Takes `req[N_REQ]` and `ptr`, returns a one-hot grant, the granted index, and `any`.
- Top level: registers, FSM, tick counter, output registers.

## Test plan
- Single request, `req_valid = 4'b0010`, `req_data[1] = 8'hA5`:
  - `req_ready = 4'b0010` for 1 cycle.
  - `tx_start` next cycle with `data_out = A5`, `grant_id = 1`.
  - Transmitter `tx` shows LSB-first `1,0,1,0,0,1,0,1` framed by start and stop.
  - `frame_done` exactly 160 counted ticks after LOAD.
- All four requesters valid continuously, data `8'h10..8'h13`:
  - Grant order 0, 1, 2, 3, 0.
  - The transmitter never sees `tx_start` while not idle; check with an assertion on its `state`.
- `sample_tick` held high for the whole LOAD cycle:
  - Not counted; `frame_done` still aligns with the transmitter returning to idle.
- `enable` low while requests are pending:
  - No grant.
  - `enable` dropped mid-frame: the current frame completes, then the block stays idle until `enable` returns high.
- `reset` pulsed at tick 70 of a frame:
  - All outputs return to reset values; `tx` goes to 1.
  - After release, a new request is served starting from requester 0.
- `DBITS = 7`, `SB_TICK = 32`:
  - `FRAME_TICKS = 160`; `frame_done` timing matches the transmitter's stop-end.
